frame_config_sequencer: RTL and testbench
=========================================

Name: frame_config_sequencer

Overview:
- Configuration controller for one fabric column of IO/logic tiles (E_IO and neighbours).
- Accepts a beat stream of frame headers and row-slice data. Assembles one full frame across all rows, then pulses the matching FrameStrobe bit so every tile in the column latches its config bits.
- Drives the column's FrameData/FrameStrobe inputs that the tiles buffer and forward.

Parameters:
- MaxFramesPerCol, 8, number of FrameStrobe lines per column.
- FrameBitsPerRow, 8, FrameData bits per tile row.
- NumRows, 4, tile rows in the column; one data beat per row.
- StrobeCycles, 2, cycles FrameStrobe stays asserted (1..15).

Ports:
- UserCLK  input  1  clock; all logic rising-edge.
- resetn  input  1  synchronous active-low reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_hdr  input  1  1 = header beat, 0 = data beat.
- in_data  input  FrameBitsPerRow  header: frame index in low clog2(MaxFramesPerCol) bits. Data: row slice, row 0 first.
- FrameData  output  NumRows*FrameBitsPerRow  row r at bits [r*FrameBitsPerRow +: FrameBitsPerRow].
- FrameStrobe  output  MaxFramesPerCol  one-hot strobe, otherwise zero.
- busy  output  1  high in any state except IDLE.
- err  output  1  sticky protocol error flag; cleared only by reset.
- frames_done  output  16  count of strobed frames; wraps at 0xFFFF->0.

Behaviour:
- Reset (resetn=0 at clock edge), from any state including mid-frame or mid-strobe:
  - state=IDLE, FrameData=0, FrameStrobe=0, err=0, frames_done=0, row counter=0.
  - Partial frame is discarded and no strobe is emitted.
- in_ready is combinational from state: 1 in IDLE and LOAD, 0 in STROBE and HOLD.
- State IDLE:
  - Header with index < MaxFramesPerCol: latch index, row_cnt=0, go to LOAD.
  - Header with index >= MaxFramesPerCol: set err, stay IDLE.
  - Data beat: consumed and dropped, set err.
- State LOAD:
  - Data beat: write in_data into row row_cnt of FrameData, row_cnt++.
  - Beat with row_cnt==NumRows-1: go to STROBE next cycle.
  - Header beat: restart with the new index (same range check as IDLE), row_cnt=0, set err. Rows already written stay until overwritten. An out-of-range header here sets err and goes to IDLE.
- State STROBE:
  - FrameStrobe = 1 << index for exactly StrobeCycles consecutive cycles, starting the cycle after the last data beat is accepted.
  - FrameData is stable throughout.
  - Then go to HOLD.
- State HOLD:
  - One cycle with FrameStrobe=0 and FrameData still held, giving tile latches hold margin.
  - frames_done++ on this cycle.
  - Then go to IDLE. FrameData is cleared to 0 on the IDLE entry edge.
- FrameStrobe and FrameData are registered outputs with no combinational path from inputs.
- Latency: last data beat accepted at cycle t -> FrameStrobe high in cycles t+1..t+StrobeCycles, HOLD at t+StrobeCycles+1, in_ready=1 again at t+StrobeCycles+2.
- Back-to-back frames:
  - A header presented while in_ready=0 simply waits; no loss.
  - A minimum frame period is 1 + NumRows + StrobeCycles + 1 cycles.
- err is sticky. It does not block operation.

Decomposition:
- Shared package cfg_seq_pkg:
  - state enum {IDLE, LOAD, STROBE, HOLD}.
  - IDX_W = clog2(MaxFramesPerCol) helper.
  - STROBE_CNT_W = 4.
- No sub-module needed. The FSM, row register file, strobe counter and frames_done counter live in one module. If tiles require it, the column's existing strobe/clock buffers stay outside this block.

Test Plan:
- Reset mid-strobe: header 2, rows 0xA1,0xB2,0xC3,0xD4. At strobe cycle 1 assert resetn=0 -> next cycle FrameStrobe=0, FrameData=0, busy=0, frames_done=0.
- Nominal frame: header 3, rows 0x11,0x22,0x33,0x44 -> FrameData=0x44332211 for 3 cycles; FrameStrobe=0x08 for exactly 2 cycles; frames_done=1; err=0.
- Backpressure: hold in_valid with a second header 5 during STROBE/HOLD -> in_ready=0 there, accepted in IDLE; second strobe=0x20; frames_done=2.
- Errors:
  - Data beat in IDLE -> err=1, no strobe.
  - Header 9 (MaxFramesPerCol=8) -> err=1, stays IDLE.
  - Header 1 after 2 rows of frame 4 -> err=1; only FrameStrobe=0x02 fires after 4 more rows.
- Wrap: preload frames_done via 65536 frames (or forced) -> counter reads 0xFFFF then 0x0000; strobes are unaffected.

Source files
------------

// File: rtl/cfg_seq_pkg.sv
// Shared types and helpers for the column frame configuration sequencer.
// Holds the FSM state encoding and width helpers.
package cfg_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STROBE,
    HOLD
  } state_e;

  localparam int unsigned STROBE_CNT_W = 4;

  function automatic int unsigned idx_w(
    input int unsigned n
  );
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_config_sequencer.sv
// Assembles one column frame from header/row beats, then pulses the
// matching FrameStrobe line so every tile latches its config bits.
module frame_config_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int unsigned MaxFramesPerCol = 8,
  parameter int unsigned FrameBitsPerRow = 8,
  parameter int unsigned NumRows         = 4,
  parameter int unsigned StrobeCycles    = 2
) (
  input  logic                       UserCLK,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_hdr,
  input  logic [FrameBitsPerRow-1:0] in_data,
  output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err,
  output logic [15:0]                frames_done
);

  localparam int unsigned IDX_W = idx_w(MaxFramesPerCol);
  localparam int unsigned ROW_W = idx_w(NumRows);
  localparam int unsigned DW    = NumRows * FrameBitsPerRow;

  localparam logic [ROW_W-1:0] LAST_ROW =
    ROW_W'(NumRows - 1);
  localparam logic [STROBE_CNT_W-1:0] SCNT_INIT =
    STROBE_CNT_W'(StrobeCycles - 1);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic [DW-1:0]              data_q, data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic [STROBE_CNT_W-1:0]    scnt_q, scnt_d;
  logic                       err_q, err_d;
  logic [15:0]                frames_done_q, frames_done_d;

  logic acc;
  logic hdr_ok;

  assign in_ready = (state_q == IDLE) ||
                    (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign err         = err_q;
  assign frames_done = frames_done_q;
  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;

  assign acc    = in_valid && in_ready;
  // Full header value is range-checked, not just the index bits.
  assign hdr_ok = 32'(in_data) < MaxFramesPerCol;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    row_d         = row_q;
    data_d        = data_q;
    strobe_d      = strobe_q;
    scnt_d        = scnt_q;
    err_d         = err_q;
    frames_done_d = frames_done_q;

    case (state_q)
      IDLE: begin
        if (acc) begin
          if (in_hdr && hdr_ok) begin
            idx_d   = in_data[IDX_W-1:0];
            row_d   = '0;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (acc && in_hdr) begin
          err_d = 1'b1;
          row_d = '0;
          if (hdr_ok) begin
            idx_d = in_data[IDX_W-1:0];
          end else begin
            data_d  = '0;
            state_d = IDLE;
          end
        end else if (acc) begin
          for (int r = 0; r < int'(NumRows); r++) begin
            if (row_q == ROW_W'(r)) begin
              data_d[r*FrameBitsPerRow +: FrameBitsPerRow] =
                in_data;
            end
          end
          row_d = row_q + 1'b1;
          if (row_q == LAST_ROW) begin
            strobe_d        = '0;
            strobe_d[idx_q] = 1'b1;
            scnt_d          = SCNT_INIT;
            state_d         = STROBE;
          end
        end
      end

      STROBE: begin
        if (scnt_q == '0) begin
          strobe_d = '0;
          state_d  = HOLD;
        end else begin
          scnt_d = scnt_q - 1'b1;
        end
      end

      HOLD: begin
        frames_done_d = frames_done_q + 16'd1;
        data_d        = '0;
        row_d         = '0;
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      row_q         <= '0;
      data_q        <= '0;
      strobe_q      <= '0;
      scnt_q        <= '0;
      err_q         <= 1'b0;
      frames_done_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      row_q         <= row_d;
      data_q        <= data_d;
      strobe_q      <= strobe_d;
      scnt_q        <= scnt_d;
      err_q         <= err_d;
      frames_done_q <= frames_done_d;
    end
  end

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed bench for frame_config_sequencer: reset, nominal frames,
// backpressure, protocol errors and frames_done wrap.
module tb_frame_config_sequencer;

  localparam int SC = 2;

  logic        UserCLK = 1'b0;
  logic        resetn  = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_hdr  = 1'b0;
  logic [7:0]  in_data = '0;
  logic [31:0] FrameData;
  logic [7:0]  FrameStrobe;
  logic        busy;
  logic        err;
  logic [15:0] frames_done;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_done = '0;

  frame_config_sequencer dut (
    .UserCLK     (UserCLK),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_hdr      (in_hdr),
    .in_data     (in_data),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .err         (err),
    .frames_done (frames_done)
  );

  always #5 UserCLK = ~UserCLK;

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic hdr, input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_hdr   = hdr;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge UserCLK);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout ready=%b required 1", in_ready);
    end
    @(negedge UserCLK);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge UserCLK);
    resetn = 1'b0;
    @(negedge UserCLK);
    resetn = 1'b1;
    exp_done = '0;
  endtask

  task automatic send_rows(input logic [31:0] rows);
    for (int r = 0; r < 4; r++) begin
      send(1'b0, rows[r*8 +: 8]);
    end
  endtask

  // Entered at cycle t+1 after the last data beat.
  task automatic expect_strobe(
    input logic [7:0]  s_exp,
    input logic [31:0] d_exp
  );
    for (int c = 0; c < SC; c++) begin
      checks++;
      if (FrameStrobe !== s_exp) begin
        errors++;
        $display("FAIL strobe_c%0d got %h exp %h",
                 c, FrameStrobe, s_exp);
      end
      checks++;
      if (FrameData !== d_exp) begin
        errors++;
        $display("FAIL data_c%0d got %h exp %h",
                 c, FrameData, d_exp);
      end
      @(negedge UserCLK);
    end
    checks++;
    if (FrameStrobe !== 8'h00 || FrameData !== d_exp ||
        busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold got s=%h d=%h b=%b r=%b exp s=00 d=%h b=1 r=0",
               FrameStrobe, FrameData, busy, in_ready, d_exp);
    end
    @(negedge UserCLK);
    exp_done = exp_done + 16'd1;
    checks++;
    if (frames_done !== exp_done) begin
      errors++;
      $display("FAIL frames_done got %h exp %h",
               frames_done, exp_done);
    end
    checks++;
    if (FrameData !== 32'h0 || busy !== 1'b0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_entry got d=%h b=%b r=%b exp d=0 b=0 r=1",
               FrameData, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge UserCLK);
    checks++;
    if (FrameData !== 32'h0 || FrameStrobe !== 8'h0 ||
        busy !== 1'b0 || err !== 1'b0 ||
        frames_done !== 16'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset got d=%h s=%h b=%b e=%b n=%h r=%b",
               FrameData, FrameStrobe, busy, err,
               frames_done, in_ready);
    end
    resetn = 1'b1;
  endtask

  task automatic test_reset_mid_strobe();
    send(1'b1, 8'd2);
    send_rows(32'hD4C3B2A1);
    checks++;
    if (FrameStrobe !== 8'h04) begin
      errors++;
      $display("FAIL mid_strobe_pre got %h exp 04", FrameStrobe);
    end
    resetn = 1'b0;
    @(negedge UserCLK);
    resetn = 1'b1;
    exp_done = '0;
    checks++;
    if (FrameStrobe !== 8'h0 || FrameData !== 32'h0 ||
        busy !== 1'b0 || frames_done !== 16'h0) begin
      errors++;
      $display("FAIL mid_strobe_reset got s=%h d=%h b=%b n=%h exp 0",
               FrameStrobe, FrameData, busy, frames_done);
    end
    @(negedge UserCLK);
    checks++;
    if (FrameStrobe !== 8'h0) begin
      errors++;
      $display("FAIL mid_strobe_after got %h exp 00", FrameStrobe);
    end
  endtask

  task automatic test_nominal();
    send(1'b1, 8'd3);
    checks++;
    if (busy !== 1'b1 || FrameStrobe !== 8'h0) begin
      errors++;
      $display("FAIL load_state got b=%b s=%h exp b=1 s=00",
               busy, FrameStrobe);
    end
    send_rows(32'h44332211);
    expect_strobe(8'h08, 32'h44332211);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL nominal_err got %b exp 0", err);
    end
  endtask

  task automatic test_back_to_back();
    send(1'b1, 8'd3);
    send_rows(32'h44332211);
    in_valid = 1'b1;
    in_hdr   = 1'b1;
    in_data  = 8'd5;
    for (int c = 0; c < SC + 1; c++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready_c%0d got %b exp 0", c, in_ready);
      end
      @(negedge UserCLK);
    end
    exp_done = exp_done + 16'd1;
    checks++;
    if (in_ready !== 1'b1 || frames_done !== exp_done) begin
      errors++;
      $display("FAIL bp_idle got r=%b n=%h exp r=1 n=%h",
               in_ready, frames_done, exp_done);
    end
    @(negedge UserCLK);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept busy got %b exp 1", busy);
    end
    send_rows(32'h8877665A);
    expect_strobe(8'h20, 32'h8877665A);
  endtask

  task automatic test_errors();
    do_reset();
    send(1'b0, 8'h55);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 ||
        FrameStrobe !== 8'h0 || FrameData !== 32'h0) begin
      errors++;
      $display("FAIL err_data_idle got e=%b b=%b s=%h d=%h",
               err, busy, FrameStrobe, FrameData);
    end
    do_reset();
    send(1'b1, 8'd9);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_hdr9 got e=%b b=%b r=%b exp 1 0 1",
               err, busy, in_ready);
    end
    do_reset();
    send(1'b1, 8'd4);
    send(1'b0, 8'hAA);
    send(1'b0, 8'hBB);
    checks++;
    if (err !== 1'b0 || FrameData !== 32'h0000BBAA) begin
      errors++;
      $display("FAIL err_partial got e=%b d=%h exp 0 0000bbaa",
               err, FrameData);
    end
    send(1'b1, 8'd1);
    checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_restart got e=%b b=%b exp 1 1", err, busy);
    end
    send_rows(32'h04030201);
    expect_strobe(8'h02, 32'h04030201);
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge UserCLK);
    force dut.frames_done_q = 16'hFFFE;
    @(negedge UserCLK);
    release dut.frames_done_q;
    exp_done = 16'hFFFE;
    send(1'b1, 8'd0);
    send_rows(32'hDEADBEEF);
    expect_strobe(8'h01, 32'hDEADBEEF);
    send(1'b1, 8'd7);
    send_rows(32'h01020304);
    expect_strobe(8'h80, 32'h01020304);
    checks++;
    if (frames_done !== 16'h0000) begin
      errors++;
      $display("FAIL wrap got %h exp 0000", frames_done);
    end
  endtask

  initial begin
    @(negedge UserCLK);
    test_reset();
    test_reset_mid_strobe();
    test_nominal();
    test_back_to_back();
    test_errors();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
